// File: rtl/led_matrix_scheduler.sv
// led_matrix_scheduler: double-buffered 8x8 dual-colour frame store with round-robin writers and row scan.
module led_matrix_scheduler #(
  parameter int SCAN_DIV = 8192,
  parameter int BLANK    = 16
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req0_valid,
  input  logic [2:0] i_req0_row,
  input  logic       i_req0_color,
  input  logic [7:0] i_req0_data,
  output logic       o_req0_ready,
  input  logic       i_req1_valid,
  input  logic [2:0] i_req1_row,
  input  logic       i_req1_color,
  input  logic [7:0] i_req1_data,
  output logic       o_req1_ready,
  input  logic       i_swap_req,
  output logic       o_swap_ack,
  output logic       o_frame_done,
  output logic [7:0] o_row,
  output logic [7:0] o_column_green,
  output logic [7:0] o_column_red
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);

  // bank, plane (0 green, 1 red), row
  logic [7:0]    r_buf [2][2][8];
  logic          r_front, r_ptr, r_pending, r_swap_ack;
  logic [2:0]    r_scan_idx;
  logic [7:0]    r_row;
  logic [DW-1:0] r_dwell;
  logic          w_last, w_frame_end, w_commit, w_g0, w_g1, w_we, w_blank;
  logic [2:0]    w_wrow;
  logic          w_wcol;
  logic [7:0]    w_wdata;

  assign w_last      = r_dwell == LAST;
  assign w_frame_end = w_last && r_scan_idx == 3'd7;
  assign w_commit    = w_frame_end && (r_pending || i_swap_req);
  // r_ptr = 1 means requester 1 is favoured on contention
  assign w_g0         = i_req0_valid && (!i_req1_valid || !r_ptr);
  assign w_g1         = i_req1_valid && (!i_req0_valid || r_ptr);
  assign o_req0_ready = w_g0 && !w_commit && i_reset;
  assign o_req1_ready = w_g1 && !w_commit && i_reset;
  assign w_we         = o_req0_ready || o_req1_ready;
  assign w_wrow       = o_req0_ready ? i_req0_row : i_req1_row;
  assign w_wcol       = o_req0_ready ? i_req0_color : i_req1_color;
  assign w_wdata      = o_req0_ready ? i_req0_data : i_req1_data;

  assign w_blank        = r_dwell < DW'(BLANK);
  assign o_column_green = w_blank ? 8'h00 : r_buf[r_front][1'b0][r_scan_idx];
  assign o_column_red   = w_blank ? 8'h00 : r_buf[r_front][1'b1][r_scan_idx];
  assign o_row          = r_row;
  assign o_frame_done   = w_frame_end;
  assign o_swap_ack     = r_swap_ack;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < 2; p++)
          for (int r = 0; r < 8; r++)
            r_buf[b][p][r] <= 8'h00;
      r_front    <= 1'b0;
      r_ptr      <= 1'b0;
      r_pending  <= 1'b0;
      r_swap_ack <= 1'b0;
      r_scan_idx <= 3'd0;
      r_row      <= 8'b1000_0000;
      r_dwell    <= '0;
    end else begin
      r_dwell <= w_last ? '0 : r_dwell + DW'(1);
      if (w_last) begin
        r_scan_idx <= r_scan_idx + 3'd1;
        r_row      <= {r_row[0], r_row[7:1]};
      end
      if (w_we) begin
        r_buf[~r_front][w_wcol][w_wrow] <= w_wdata;
        r_ptr                           <= o_req0_ready;
      end
      r_swap_ack <= w_commit;
      if (w_commit) begin
        r_front   <= ~r_front;
        r_pending <= 1'b0;
      end else if (i_swap_req) begin
        r_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_led_matrix_scheduler.sv
// tb_led_matrix_scheduler: directed table, corner sequences and random traffic against a frame-time model.
module tb_led_matrix_scheduler;
  localparam int SD = 4;
  localparam int BL = 1;
  localparam int FRAME = 8 * SD;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, c0, v1, c1, swq;
  logic [2:0] r0, r1;
  logic [7:0] d0, d1;
  logic       rdy0, rdy1, ack, fd;
  logic [7:0] row, cg, cr;

  always #5 clk = ~clk;

  led_matrix_scheduler #(.SCAN_DIV(SD), .BLANK(BL)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(v0), .i_req0_row(r0), .i_req0_color(c0), .i_req0_data(d0), .o_req0_ready(rdy0),
    .i_req1_valid(v1), .i_req1_row(r1), .i_req1_color(c1), .i_req1_data(d1), .o_req1_ready(rdy1),
    .i_swap_req(swq), .o_swap_ack(ack), .o_frame_done(fd),
    .o_row(row), .o_column_green(cg), .o_column_red(cr)
  );

  int passed = 0;
  int total  = 0;

  // model: time since reset picks the scan position; memory indexed by bank/plane/row
  int         t;
  logic [7:0] m_mem [2][2][8];
  logic       m_front, m_pend, m_ack, m_fav;
  logic       e_r0, e_r1, e_fd, e_ack, e_commit;
  logic [7:0] e_row, e_cg, e_cr;
  logic       cap_r0, cap_r1, cap_fd, cap_ack;
  logic [7:0] cap_cg, cap_cr;

  typedef struct {
    logic v0, c0, v1, c1;
    logic [2:0] r0, r1;
    logic [7:0] d0, d1;
    logic e0, e1;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, t);
  endtask

  function automatic int pos();
    return t % FRAME;
  endfunction

  task automatic model_reset();
    t = 0; m_front = 0; m_pend = 0; m_ack = 0; m_fav = 0;
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < 2; p++)
        for (int r = 0; r < 8; r++)
          m_mem[b][p][r] = 8'h00;
  endtask

  task automatic calc();
    int sidx, dw;
    sidx     = pos() / SD;
    dw       = pos() % SD;
    e_fd     = pos() == FRAME - 1;
    e_commit = e_fd && (m_pend || swq);
    e_row    = 8'h80 >> sidx;
    e_cg     = dw < BL ? 8'h00 : m_mem[m_front][0][sidx];
    e_cr     = dw < BL ? 8'h00 : m_mem[m_front][1][sidx];
    e_r0     = rst && !e_commit && v0 && (!v1 || !m_fav);
    e_r1     = rst && !e_commit && v1 && (!v0 || m_fav);
    e_ack    = m_ack;
  endtask

  task automatic step();
    calc();
    #1;
    cap_r0 = rdy0; cap_r1 = rdy1; cap_fd = fd; cap_ack = ack; cap_cg = cg; cap_cr = cr;
    chk("ready0", {7'd0, rdy0}, {7'd0, e_r0});
    chk("ready1", {7'd0, rdy1}, {7'd0, e_r1});
    chk("frame_done", {7'd0, fd}, {7'd0, e_fd});
    chk("swap_ack", {7'd0, ack}, {7'd0, e_ack});
    chk("row", row, e_row);
    chk("column_green", cg, e_cg);
    chk("column_red", cr, e_cr);
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      if (e_r0) begin m_mem[!m_front][c0][r0] = d0; m_fav = 1; end
      else if (e_r1) begin m_mem[!m_front][c1][r1] = d1; m_fav = 0; end
      m_ack = e_commit;
      if (e_commit) begin m_front = !m_front; m_pend = 0; end
      else if (swq) m_pend = 1;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; c0 = 0; c1 = 0; r0 = 0; r1 = 0; d0 = 0; d1 = 0; swq = 0;
  endtask

  task automatic run_until(input int p);
    int n = 0;
    while (pos() != p && n < 2 * FRAME) begin step(); n++; end
    if (pos() != p) begin total++; $display("FAIL run_until: got pos %0d expected %0d", pos(), p); end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin step(); n++; end while (!cap_ack && n < 2 * FRAME);
    chk(name, {7'd0, cap_ack}, 8'd1);
  endtask

  initial begin
    int fd_idx, acks;
    tbl[0] = '{1, 0, 1, 1, 3'd2, 3'd5, 8'hAA, 8'h55, 1, 0};
    tbl[1] = '{1, 0, 1, 1, 3'd2, 3'd5, 8'hAA, 8'h55, 0, 1};
    tbl[2] = '{1, 0, 1, 1, 3'd2, 3'd5, 8'hAA, 8'h55, 1, 0};
    tbl[3] = '{1, 0, 1, 1, 3'd2, 3'd5, 8'hAA, 8'h55, 0, 1};
    idle();
    rst = 0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) step();
    rst = 1;
    fd_idx = -1;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (cap_fd && fd_idx < 0) fd_idx = i;
    end
    chk("frame_done_cycle", 8'(fd_idx), 8'd31);
    for (int i = 0; i < 4; i++) begin
      {v0, c0, v1, c1, r0, r1, d0, d1} = {tbl[i].v0, tbl[i].c0, tbl[i].v1, tbl[i].c1,
                                          tbl[i].r0, tbl[i].r1, tbl[i].d0, tbl[i].d1};
      step();
      chk("tbl_ready0", {7'd0, cap_r0}, {7'd0, tbl[i].e0});
      chk("tbl_ready1", {7'd0, cap_r1}, {7'd0, tbl[i].e1});
    end
    idle();
    run_until(10);
    swq = 1; step(); swq = 0;
    wait_ack("swap_ack_first");
    run_until(8); step();
    chk("row2_blank", cap_cg, 8'h00);
    step();
    chk("row2_green", cap_cg, 8'hAA);
    run_until(21); step();
    chk("row5_red", cap_cr, 8'h55);
    run_until(30);
    swq = 1; step(); swq = 0;
    v0 = 1; r0 = 3'd1; c0 = 0; d0 = 8'h3C;
    step();
    chk("commit_blocks_ready0", {7'd0, cap_r0}, 8'd0);
    swq = 1;
    step();
    chk("ready0_after_commit", {7'd0, cap_r0}, 8'd1);
    chk("ack_after_commit", {7'd0, cap_ack}, 8'd1);
    idle();
    wait_ack("second_swap_ack");
    run_until(5); step();
    chk("orig_front_row1", cap_cg, 8'h3C);
    run_until(1);
    swq = 1; acks = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin step(); acks += int'(cap_ack); end
    swq = 0;
    chk("held_swap_acks", 8'(acks), 8'd3);
    run_until(5);
    swq = 1; step(); swq = 0;
    run_until(16);
    rst = 0; v1 = 1; r1 = 3'd6; c1 = 1; d1 = 8'hF0;
    step();
    rst = 1;
    step();
    chk("req1_reaccepted", {7'd0, cap_r1}, 8'd1);
    idle();
    acks = 0;
    for (int i = 0; i < FRAME + 4; i++) begin step(); acks += int'(cap_ack); end
    chk("no_ack_after_reset", 8'(acks), 8'd0);
    for (int i = 0; i < 600; i++) begin
      if (!(v0 && !e_r0)) begin
        v0 = $urandom_range(0, 1); r0 = 3'($urandom); c0 = 1'($urandom); d0 = 8'($urandom);
      end
      if (!(v1 && !e_r1)) begin
        v1 = $urandom_range(0, 1); r1 = 3'($urandom); c1 = 1'($urandom); d1 = 8'($urandom);
      end
      swq = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 249) != 0;
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
